i3c_phy_lanes: RTL
==================

// Module: i3c_phy_lanes
// PURPOSE
// - Parametrised multi-lane I3C/I2C pad PHY. Generalises the single SCL/SDA phy+io pair to NUM_LANES lines.
// - Per lane: input synchroniser, spike filter, edge detect, and per-lane open-drain/push-pull drive.
// - Push-pull to open-drain high-keeper handoff; bus-free detection across all lanes.
// - Sits between the controller/target FSMs (ctrl_*) and the tri-state pad cells (pad_*).
// PARAMETERS
// - NUM_LANES        2   number of bus lines (lane 0 = SCL, lane 1 = SDA, rest generic)
// - SYNC_STAGES      2   input synchroniser flops, >=2
// - FILT_CYCLES      1   consecutive stable cycles required to accept an input change, >=1 (1 = no filtering)
// - HANDOFF_CYCLES   2   cycles high is kept driven after a PP->OD switch while driving high, >=0
// - BUS_IDLE_CYCLES  16  cycles all lanes must read high before bus_free_o, >=1
// PORTS
// - clk_i        in   1          single clock domain
// - rst_i        in   1          synchronous reset, active-high
// - pad_i        in   NUM_LANES  raw pad input (asynchronous)
// - pad_o        out  NUM_LANES  pad output value
// - pad_oe_o     out  NUM_LANES  pad output enable (1 = drive pad_o)
// - ctrl_i       in   NUM_LANES  line value requested by controller
// - pp_en_i      in   NUM_LANES  1 = push-pull, 0 = open-drain, per lane
// - ctrl_o       out  NUM_LANES  synchronised, filtered line value
// - rise_o       out  NUM_LANES  one-cycle pulse on filtered 0->1
// - fall_o       out  NUM_LANES  one-cycle pulse on filtered 1->0
// - bus_free_o   out  1          all lanes high for >= BUS_IDLE_CYCLES
// BEHAVIOUR
// - Reset, on a clk_i edge with rst_i=1:
//   - sync chains, ctrl_o and filter state = all 1s (idle-high bus).
//   - pad_oe_o=0, pad_o=0, rise_o=0, fall_o=0, bus_free_o=0.
//   - All counters = 0; handoff inactive.
// - Input path, per lane:
//   - pad_i runs through SYNC_STAGES flops to give sync.
//   - Filter counter increments each cycle sync != ctrl_o; it clears when sync == ctrl_o.
//   - When the counter reaches FILT_CYCLES-1 and the mismatch persists, ctrl_o <= sync next edge and the counter clears.
//   - A stable pad change reaches ctrl_o exactly SYNC_STAGES+FILT_CYCLES cycles later.
//   - A pulse shorter than FILT_CYCLES synced cycles never reaches ctrl_o.
//   - rise_o/fall_o are asserted in the first cycle ctrl_o shows the new value, for exactly 1 cycle.
// - Output path, per lane; registered, latency 1 cycle from ctrl_i/pp_en_i to pad_*:
//   - PP: pad_oe_o=1, pad_o=ctrl_i.
//   - OD: pad_oe_o=~ctrl_i, pad_o=0. Pad_o is never 1 while in OD, except during handoff.
// - Handoff, per lane: pp_en_i falls while the lane is driving high (pad_oe_o=1, pad_o=1):
//   - Enter HANDOFF: hold pad_oe_o=1, pad_o=1 for HANDOFF_CYCLES cycles, then release (pad_oe_o=0).
//   - ctrl_i=0 during HANDOFF: abort; next cycle pad_oe_o=1, pad_o=0 (OD low).
//   - pp_en_i=1 during HANDOFF: abort; resume PP.
//   - HANDOFF_CYCLES=0: release on the normal 1-cycle latency.
//   - Lane states: PP, OD, HANDOFF. Transitions:
//     - PP->OD when driving low.
//     - PP->HANDOFF when driving high.
//     - HANDOFF->OD on count done or ctrl_i=0.
//     - HANDOFF->PP on pp_en_i=1.
//     - OD->PP when pp_en_i=1.
// - Bus-free:
//   - Idle counter increments while all ctrl_o bits = 1 and saturates at BUS_IDLE_CYCLES.
//   - Any ctrl_o bit = 0 clears it in the same cycle.
//   - bus_free_o = (counter == BUS_IDLE_CYCLES), registered.
// - Reset mid-operation (handoff, filtering, idle count) abandons all state and returns to the reset values above.
// - All counters are sized $clog2(max+1). No wrap-around is possible.
// TESTING
// - Reset: hold rst_i 2 cycles.
//   -> ctrl_o=all 1s, pad_oe_o=0, pad_o=0, rise_o=fall_o=0, bus_free_o=0.
// - Filter (FILT_CYCLES=4, SYNC_STAGES=2):
//   -> 3-cycle low spike on pad_i[1]: no fall_o.
//   -> 5-cycle low pulse: fall_o[1] asserted 6 cycles after the falling pad edge.
// - Drive modes: ctrl_i=0/1 with pp_en_i=0.
//   -> pad_oe_o = 1/0 and pad_o=0, one cycle later.
//   -> with pp_en_i=1: pad_oe_o=1, pad_o=ctrl_i.
// - Handoff (HANDOFF_CYCLES=2): PP high, then drop pp_en_i.
//   -> pad_oe_o=1, pad_o=1 for 2 cycles, then pad_oe_o=0.
//   -> repeat with ctrl_i=0 in the 1st handoff cycle: pad_oe_o=1, pad_o=0 next cycle.
// - Bus-free (BUS_IDLE_CYCLES=16):
//   -> all pads high: bus_free_o rises after 16 cycles of ctrl_o=1s.
//   -> 1-cycle accepted low on any lane: bus_free_o drops and the count restarts.
// - Reset mid-handoff and mid-filter count.
//   -> outputs return to reset values the cycle after rst_i.
//   -> no stale rise_o/fall_o pulses afterwards.

Source files
------------

// File: rtl/i3c_phy_lanes.sv
// Multi-lane I3C/I2C pad PHY.
// Each lane has an input synchroniser, a spike filter and edge detect on the
// receive side, and a registered open-drain/push-pull driver on the transmit
// side. A lane that leaves push-pull while driving high keeps the line
// actively high for a few cycles before letting the pull-up take over.
// Bus-free is reported once every filtered line has been high long enough.
module i3c_phy_lanes #(
   parameter int NUM_LANES       = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int FILT_CYCLES     = 1,
   parameter int HANDOFF_CYCLES  = 2,
   parameter int BUS_IDLE_CYCLES = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_LANES-1:0] pad_i,
   output logic [NUM_LANES-1:0] pad_o,
   output logic [NUM_LANES-1:0] pad_oe_o,
   input  logic [NUM_LANES-1:0] ctrl_i,
   input  logic [NUM_LANES-1:0] pp_en_i,
   output logic [NUM_LANES-1:0] ctrl_o,
   output logic [NUM_LANES-1:0] rise_o,
   output logic [NUM_LANES-1:0] fall_o,
   output logic                 bus_free_o
);

   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int HW = (HANDOFF_CYCLES > 0) ? $clog2(HANDOFF_CYCLES + 1) : 1;
   localparam int IW = $clog2(BUS_IDLE_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
   localparam logic [HW-1:0] HO_LAST   = HW'((HANDOFF_CYCLES > 0) ? HANDOFF_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(BUS_IDLE_CYCLES);
   localparam logic          HO_EN     = (HANDOFF_CYCLES > 0);

   typedef enum logic [1:0] {
      LANE_PP,
      LANE_OD,
      LANE_HANDOFF
   } lane_state_t;

   // Filtered line values as they will appear after the next edge; used by
   // the idle counter so it clears in the same cycle a low shows on ctrl_o.
   logic [NUM_LANES-1:0] ctrl_next;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [FW-1:0]          filt_cnt_reg;
      logic                   line_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   sync_bit;
      logic                   filt_take;

      lane_state_t            state_reg;
      lane_state_t            state_next;
      logic [HW-1:0]          ho_cnt_reg;
      logic [HW-1:0]          ho_cnt_next;
      logic                   pad_o_reg;
      logic                   pad_o_next;
      logic                   pad_oe_reg;
      logic                   pad_oe_next;
      logic                   driving_high;

      assign sync_bit      = sync_reg[SYNC_STAGES-1];
      assign filt_take     = (sync_bit != line_reg) && (filt_cnt_reg == FILT_LAST);
      assign ctrl_next[gi] = filt_take ? sync_bit : line_reg;
      assign driving_high  = pad_oe_reg & pad_o_reg;

      assign ctrl_o[gi]   = line_reg;
      assign rise_o[gi]   = rise_reg;
      assign fall_o[gi]   = fall_reg;
      assign pad_o[gi]    = pad_o_reg;
      assign pad_oe_o[gi] = pad_oe_reg;

      // Synchroniser chain; idles high so reset does not look like a bus event
      always_ff @(posedge clk_i) begin
         if (rst_i) sync_reg <= '1;
         else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_i[gi]};
      end

      // Spike filter: accept a new level only after it has persisted, and flag the edge
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            filt_cnt_reg <= '0;
            line_reg     <= 1'b1;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
         end else begin
            if ((sync_bit == line_reg) || filt_take) filt_cnt_reg <= '0;
            else                                     filt_cnt_reg <= filt_cnt_reg + 1'b1;
            line_reg <= ctrl_next[gi];
            rise_reg <= filt_take & sync_bit;
            fall_reg <= filt_take & ~sync_bit;
         end
      end

      // Driver mode register plus the registered pad outputs
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_reg  <= LANE_OD;
            ho_cnt_reg <= '0;
            pad_o_reg  <= 1'b0;
            pad_oe_reg <= 1'b0;
         end else begin
            state_reg  <= state_next;
            ho_cnt_reg <= ho_cnt_next;
            pad_o_reg  <= pad_o_next;
            pad_oe_reg <= pad_oe_next;
         end
      end

      // Mode transitions; a high-driving PP lane dropping to OD goes through handoff
      always_comb begin
         state_next  = state_reg;
         ho_cnt_next = '0;
         case (state_reg)
            LANE_PP: begin
               if (!pp_en_i[gi]) begin
                  if (HO_EN && driving_high && ctrl_i[gi]) state_next = LANE_HANDOFF;
                  else                                     state_next = LANE_OD;
               end
            end
            LANE_HANDOFF: begin
               if (pp_en_i[gi])                               state_next = LANE_PP;
               else if (!ctrl_i[gi] || (ho_cnt_reg == HO_LAST)) state_next = LANE_OD;
               else                                           ho_cnt_next = ho_cnt_reg + 1'b1;
            end
            LANE_OD: begin
               if (pp_en_i[gi]) state_next = LANE_PP;
            end
            default: state_next = LANE_OD;
         endcase
      end

      // Pad drive for the mode being entered; OD only ever pulls low
      always_comb begin
         pad_o_next  = 1'b0;
         pad_oe_next = ~ctrl_i[gi];
         case (state_next)
            LANE_PP: begin
               pad_oe_next = 1'b1;
               pad_o_next  = ctrl_i[gi];
            end
            LANE_HANDOFF: begin
               pad_oe_next = 1'b1;
               pad_o_next  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic [IW-1:0] idle_cnt_reg;
   logic [IW-1:0] idle_cnt_next;
   logic          bus_free_reg;

   assign bus_free_o = bus_free_reg;

   // Saturating count of cycles with every filtered line high
   always_comb begin
      idle_cnt_next = '0;
      if (&ctrl_next) begin
         if (idle_cnt_reg == IDLE_MAX) idle_cnt_next = idle_cnt_reg;
         else                          idle_cnt_next = idle_cnt_reg + 1'b1;
      end
   end

   // Idle counter and registered bus-free flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idle_cnt_reg <= '0;
         bus_free_reg <= 1'b0;
      end else begin
         idle_cnt_reg <= idle_cnt_next;
         bus_free_reg <= (idle_cnt_next == IDLE_MAX);
      end
   end

endmodule
